// File: rtl/contador_regressivo.sv
// contador_regressivo: programmable down-counting timer with a start/done FSM.
// Loads the limit D on start, counts down to zero while ent && enp are both
// high, flags terminal count on brw and pulses pronto when the interval ends.
// With RECARGA = 1 the counter reloads D at terminal count and keeps running.
//
// Control handshake: iniciar is a level request taken only while idle (OCIOSO).
// ocupado is high for exactly as long as the timer is counting (CONTA).
// pronto is a one-cycle completion pulse; the control unit must not rely on
// iniciar being acknowledged other than by ocupado rising after the edge.
module contador_regressivo #(
  parameter int N       = 4,
  parameter bit RECARGA = 1'b0
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         iniciar,
  input  logic         parar,
  input  logic         ent,
  input  logic         enp,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         brw,
  output logic         ocupado,
  output logic         pronto,
  output logic [1:0]   estado
);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] CONTA  = 2'd1;
  localparam logic [1:0] FIM    = 2'd2;

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] UM   = {{(N-1){1'b0}}, 1'b1};

  logic step;
  logic terminal;

  // A count step needs both enables; terminal count is the zero value.
  always_comb begin
    step     = ent && enp;
    terminal = (Q == ZERO);
  end

  // Borrow follows ent combinationally and ignores enp, like the up-counter carry.
  always_comb begin
    brw = (estado == CONTA) && ent && terminal;
  end

  // FSM, count register and registered status flags.
  always_ff @(posedge clock) begin
    if (!clr) begin
      estado  <= OCIOSO;
      Q       <= ZERO;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            Q       <= D;
            estado  <= CONTA;
            ocupado <= 1'b1;
          end
        end
        CONTA: begin
          if (parar) begin
            // Abort keeps the partial count visible and skips the pulse.
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end else if (step) begin
            if (!terminal) begin
              Q <= Q - UM;
            end else if (RECARGA) begin
              Q      <= D;
              pronto <= 1'b1;
            end else begin
              estado  <= FIM;
              ocupado <= 1'b0;
              pronto  <= 1'b1;
            end
          end
        end
        FIM: begin
          // One cycle of pronto, then back to idle; iniciar is not looked at here.
          estado <= OCIOSO;
        end
        default: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contador_regressivo.sv
// Bench for contador_regressivo: one one-shot and one auto-reload instance
// share the same stimulus and are compared every cycle against an
// interval-level reference model.
module tb_contador_regressivo;

  localparam int N = 4;

  logic         clock;
  logic         clr;
  logic         iniciar;
  logic         parar;
  logic         ent;
  logic         enp;
  logic [N-1:0] D;

  logic [N-1:0] q_os, q_rl;
  logic         brw_os, brw_rl;
  logic         ocup_os, ocup_rl;
  logic         pr_os, pr_rl;
  logic [1:0]   st_os, st_rl;

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 one-shot, index 1 auto-reload.
  int m_q    [2];
  bit m_run  [2];
  bit m_done [2];
  bit m_pr   [2];

  contador_regressivo #(.N(N), .RECARGA(1'b0)) dut_os (
    .clock(clock), .clr(clr), .iniciar(iniciar), .parar(parar),
    .ent(ent), .enp(enp), .D(D), .Q(q_os), .brw(brw_os),
    .ocupado(ocup_os), .pronto(pr_os), .estado(st_os)
  );

  contador_regressivo #(.N(N), .RECARGA(1'b1)) dut_rl (
    .clock(clock), .clr(clr), .iniciar(iniciar), .parar(parar),
    .ent(ent), .enp(enp), .D(D), .Q(q_rl), .brw(brw_rl),
    .ocupado(ocup_rl), .pronto(pr_rl), .estado(st_rl)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!clr) begin
        m_q[k] = 0; m_run[k] = 0; m_done[k] = 0; m_pr[k] = 0;
      end else if (m_done[k]) begin
        m_done[k] = 0; m_pr[k] = 0;
      end else if (!m_run[k]) begin
        m_pr[k] = 0;
        if (iniciar) begin
          m_q[k] = D; m_run[k] = 1;
        end
      end else begin
        m_pr[k] = 0;
        if (parar) begin
          m_run[k] = 0;
        end else if (ent && enp) begin
          if (m_q[k] > 0) m_q[k] = m_q[k] - 1;
          else if (k == 1) begin
            m_q[k] = D; m_pr[k] = 1;
          end else begin
            m_run[k] = 0; m_done[k] = 1; m_pr[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("q_oneshot",    q_os,    m_q[0]);
    check("ocup_oneshot", ocup_os, m_run[0]);
    check("pr_oneshot",   pr_os,   m_pr[0]);
    check("brw_oneshot",  brw_os,  m_run[0] && ent && m_q[0] == 0);
    check("q_reload",     q_rl,    m_q[1]);
    check("ocup_reload",  ocup_rl, m_run[1]);
    check("pr_reload",    pr_rl,   m_pr[1]);
    check("brw_reload",   brw_rl,  m_run[1] && ent && m_q[1] == 0);
  endtask

  // One clock: edge, model update, sample 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_step();
      #1;
      compare_all();
    end
  endtask

  task automatic drive(input logic c, input logic i, input logic p,
                       input logic e, input logic ep, input logic [N-1:0] d);
    clr = c; iniciar = i; parar = p; ent = e; enp = ep; D = d;
  endtask

  task automatic start(input logic [N-1:0] d);
    drive(1, 1, 0, 1, 1, d);
    tick();
    iniciar = 0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0; m_run[k] = 0; m_done[k] = 0; m_pr[k] = 0;
    end
    drive(0, 0, 0, 0, 0, '0);
    #2;
    tick(2);
    check("reset_q", q_os, 0);
    check("reset_brw", brw_os, 0);

    // One-shot D = 5: 5,4,3,2,1,0 then FIM then idle.
    start(4'd5);
    check("load_q", q_os, 5);
    tick(5);
    check("term_q", q_os, 0);
    check("term_brw", brw_os, 1);
    tick();
    check("fim_pronto", pr_os, 1);
    check("fim_ocupado", ocup_os, 0);
    iniciar = 1;            // ignored in FIM
    tick();
    check("idle_pronto", pr_os, 0);
    check("idle_ocupado", ocup_os, 0);
    iniciar = 0;
    tick(2);

    // Pause with enp low at Q = 2, then ent low at Q = 0.
    start(4'd3);
    tick();
    enp = 0;
    tick(4);
    check("pause_q", q_os, 2);
    enp = 1;
    tick(2);
    ent = 0;
    tick(2);
    check("ent_low_brw", brw_os, 0);
    ent = 1;
    tick(3);

    // Abort at Q = 4, then restart with D = 2; iniciar mid-count is ignored.
    start(4'd9);
    tick(5);
    check("abort_pre_q", q_os, 4);
    parar = 1;
    tick();
    check("abort_q", q_os, 4);
    check("abort_ocupado", ocup_os, 0);
    parar = 0;
    start(4'd2);
    iniciar = 1; D = 4'd7;
    tick(2);
    iniciar = 0;
    tick(3);

    // Auto-reload period with D changed mid-period.
    start(4'd2);
    tick(7);
    D = 4'd1;
    tick(6);
    parar = 1;
    tick();
    parar = 0;
    tick();

    // D = 0 and D = 15 boundaries.
    start(4'd0);
    tick(3);
    start(4'd15);
    tick(18);

    // Reset on the terminal-count edge.
    start(4'd1);
    tick();
    clr = 0;
    tick();
    check("clr_term_pronto", pr_os, 0);
    clr = 1;
    tick();

    // Parar and terminal count together.
    start(4'd1);
    tick();
    parar = 1;
    tick();
    parar = 0;
    tick();

    // Randomized stimulus.
    for (int c = 0; c < 3000; c++) begin
      clr     = ($urandom_range(0, 63) != 0);
      iniciar = ($urandom_range(0, 3) == 0);
      parar   = ($urandom_range(0, 15) == 0);
      ent     = ($urandom_range(0, 7) != 0);
      enp     = ($urandom_range(0, 7) != 0);
      D       = N'($urandom_range(0, 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_regressivo.md
# contador_regressivo

Programmable down-counting timer for the control-unit experiments. It is the counterpart of the up-counter with ripple-carry-out: it loads a limit, counts down to zero under the same dual-enable discipline, and flags terminal count with a borrow output. A small start/done FSM lets the control unit start a timed interval and wait for a completion pulse. It sits beside the datapath counters, driven by the control unit's start, abort and enable signals.

## Interface
- N, 4, counter width in bits
- RECARGA, 0, 1 = auto-reload D on terminal count and keep counting; 0 = one-shot
- clock  in  1  system clock; all state changes on rising edge
- clr  in  1  synchronous active-low reset; dominates every other input
- iniciar  in  1  start request; sampled only in OCIOSO
- parar  in  1  abort; active-high, sampled in CONTA
- ent  in  1  count enable, also gates brw
- enp  in  1  count enable (count step only when ent && enp)
- D  in  N  load value (limit), sampled at start and at each reload
- Q  out  N  registered count value
- brw  out  1  combinational borrow: CONTA && ent && Q == 0
- ocupado  out  1  registered, 1 while in CONTA
- pronto  out  1  registered, one-cycle completion pulse

## Operation
- States: OCIOSO, CONTA, FIM. Reset (clr = 0 at an edge): state OCIOSO, Q = 0, ocupado = 0, pronto = 0; brw therefore 0.
- OCIOSO: Q holds. iniciar = 1 -> Q <= D, go to CONTA.
- CONTA, priority order at each edge:
  - parar = 1 -> go to OCIOSO, Q holds its current value, no pronto.
  - ent && enp && Q != 0 -> Q <= Q - 1.
  - ent && enp && Q == 0, RECARGA = 0 -> go to FIM, Q stays 0.
  - ent && enp && Q == 0, RECARGA = 1 -> Q <= D (current D), stay in CONTA, pronto <= 1 for the next cycle only.
  - otherwise hold (either enable low pauses the count).
- FIM: pronto = 1, ocupado = 0, Q = 0; unconditionally go to OCIOSO on the next edge. iniciar is ignored in FIM.
- iniciar is ignored in CONTA; an interval is never restarted mid-count.
- Arithmetic: unsigned modulo 2^N; Q never decrements below 0 (0 is terminal, no wrap to 2^N-1).
- D = 0 is legal: one enabled cycle reaches terminal count.
- A full interval takes exactly D+1 enabled cycles from load to terminal-count edge.

## Timing
- iniciar high at edge k: Q = D and ocupado = 1 after edge k.
- Enables held high: Q = D-j after edge k+j. Q = 0 after edge k+D, with brw = 1 during that cycle. FIM is entered at edge k+D+1, so pronto = 1 and ocupado = 0 during the following cycle. OCIOSO is entered at edge k+D+2, with pronto = 0.
- RECARGA = 1: the reload edge sets pronto = 1 for exactly one cycle, and ocupado stays 1. The period is D+1 enabled cycles.
- brw responds combinationally to ent within the same cycle. It is independent of enp, in the same way the up-counter's carry is independent of enp.
- clr = 0 mid-count: the next edge forces the reset values. No pronto pulse is produced.
- parar and terminal count at the same edge: parar wins, giving OCIOSO with no pronto.

## Test plan
- Reset: drive clr = 0 for 1 edge in any state -> Q = 0, ocupado = 0, pronto = 0, brw = 0.
- One-shot, N = 4, D = 5, ent = enp = 1, pulse iniciar -> Q steps 5, 4, 3, 2, 1, 0. brw = 1 only while Q = 0. pronto is high for one cycle, 7 cycles after the load edge. The FSM then returns to OCIOSO with Q = 0.
- Pause: D = 3, drop enp for 4 cycles while Q = 2 -> Q holds 2 and brw = 0. Resuming gives pronto after the remaining 3 enabled cycles. With ent = 0 and Q = 0, brw = 0.
- Abort: D = 9, assert parar when Q = 4 -> OCIOSO, Q holds 4, ocupado = 0, no pronto. A subsequent iniciar with D = 2 reloads correctly.
- Auto-reload, RECARGA = 1, D = 2, enables high for 12 cycles -> sequence 2, 1, 0, 2, 1, 0, and so on. pronto pulses every 3 cycles and ocupado stays 1. Changing D to 1 mid-period takes effect at the next reload.
- Boundary: D = 0 gives pronto one cycle after FIM entry at load+1. D = 15 gives 16 enabled cycles. iniciar asserted during CONTA and during FIM is ignored. clr asserted on the terminal-count edge gives reset values and no pronto.
